l2_evict_buffer: RTL and testbench

Multi-entry eviction write buffer between the L2 cache's memory-side wishbone master and the physical-memory wishbone bus. It absorbs dirty-line writebacks from L2 and acknowledges them in one cycle. It drains them to pmem in FIFO order whenever the bus is free, and serves L2 line reads either from matching buffered entries or by forwarding to pmem. Reads take priority over pending drains.

---
 rtl/l2_evict_pkg.sv | 22 ++
 rtl/l2_evict_buffer_match.sv | 48 ++++
 rtl/l2_evict_buffer.sv | 199 +++++++++++++++++++
 tb/tb_l2_evict_buffer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_evict_pkg.sv
// l2_evict_pkg: shared types and default widths for the L2 eviction buffer.
//   L2E_ADDR_W / L2E_DATA_W : default line-address and line-data widths
//   evict_entry_t           : one buffered line {valid, adr, data}
//   evict_state_t           : pmem-side FSM states
package l2_evict_pkg;

  localparam int L2E_ADDR_W = 12;
  localparam int L2E_DATA_W = 128;

  typedef struct packed {
    logic                  valid;
    logic [L2E_ADDR_W-1:0] adr;
    logic [L2E_DATA_W-1:0] data;
  } evict_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2
  } evict_state_t;

endpackage

// File: rtl/l2_evict_buffer_match.sv
// evict_match: combinational address compare across all buffer entries.
//   i_valid/i_adr : per-entry valid bits and line addresses
//   i_key         : address being looked up (L2 request address)
//   i_head        : head pointer
//   i_head_busy   : head entry is (or is about to be) in flight to pmem
//   o_match       : per-entry match vector
//   o_hit/o_idx   : any match / index of a matching entry
//   o_head_mask   : one-hot head mask, only set while the head is in flight
//   o_cidx        : index of a match that excludes the in-flight head
module evict_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_adr,
  input  logic [ADDR_W-1:0]            i_key,
  input  logic [PTR_W-1:0]             i_head,
  input  logic                         i_head_busy,
  output logic [DEPTH-1:0]             o_match,
  output logic                         o_hit,
  output logic [PTR_W-1:0]             o_idx,
  output logic [DEPTH-1:0]             o_head_mask,
  output logic [PTR_W-1:0]             o_cidx
);

  logic [DEPTH-1:0] w_match;
  logic [DEPTH-1:0] w_cmatch;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign w_match[gi]     = i_valid[gi] && (i_adr[gi] == i_key);
    assign o_head_mask[gi] = i_head_busy && (i_head == PTR_W'(gi));
  end

  assign w_cmatch = w_match & ~o_head_mask;
  assign o_match  = w_match;
  assign o_hit    = |w_match;

  always_comb begin
    o_idx  = '0;
    o_cidx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_match[i])  o_idx  = PTR_W'(i);
      if (w_cmatch[i]) o_cidx = PTR_W'(i);
    end
  end

endmodule

// File: rtl/l2_evict_buffer.sv
// l2_evict_buffer: multi-entry dirty-line write buffer between the L2
// memory-side wishbone master and the pmem wishbone bus.
//   clk, rst          : clock, async active-high reset
//   i_l2_*            : L2 request (adr, dat_m, stb, cyc, we, sel)
//   o_l2_dat_s/ack    : read data / one-cycle acknowledge to L2
//   o_mem_*           : registered pmem request (adr, dat_m, stb, cyc, we, sel)
//   i_mem_dat_s/ack   : pmem read data / acknowledge
//   o_full, o_busy    : buffer full / buffer non-empty or pmem transfer active
// Writebacks are acked in one cycle and drained in FIFO order; reads hit in
// the buffer or go to pmem, and a pending read miss beats the next drain.
module l2_evict_buffer
  import l2_evict_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = L2E_ADDR_W,
  parameter int DATA_W = L2E_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_l2_adr,
  input  logic [DATA_W-1:0]   i_l2_dat_m,
  input  logic                i_l2_stb,
  input  logic                i_l2_cyc,
  input  logic                i_l2_we,
  input  logic [DATA_W/8-1:0] i_l2_sel,
  output logic [DATA_W-1:0]   o_l2_dat_s,
  output logic                o_l2_ack,
  output logic [ADDR_W-1:0]   o_mem_adr,
  output logic [DATA_W-1:0]   o_mem_dat_m,
  output logic                o_mem_stb,
  output logic                o_mem_cyc,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_sel,
  input  logic [DATA_W-1:0]   i_mem_dat_s,
  input  logic                i_mem_ack,
  output logic                o_full,
  output logic                o_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  evict_state_t r_state, w_state_nxt;

  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] r_adr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [PTR_W-1:0]             r_head, r_tail;
  logic [CNT_W-1:0]             r_count;

  // Read miss latched until its pmem transfer completes; also blocks new requests.
  logic                r_rd_pend;
  logic [ADDR_W-1:0]   r_rd_adr;

  logic                r_ack;
  logic [DATA_W-1:0]   r_dat_s;
  logic [ADDR_W-1:0]   r_mem_adr;
  logic [DATA_W-1:0]   r_mem_dat;
  logic                r_mem_we;

  logic                w_req, w_full, w_head_busy;
  logic                w_hit, w_chit;
  logic [PTR_W-1:0]    w_idx, w_cidx, w_rd_idx;
  logic [DEPTH-1:0]    w_match, w_head_mask;
  logic                w_wr_coal, w_wr_alloc, w_rd_hit, w_rd_miss;
  logic                w_pop, w_rd_done;
  logic                w_launch_rd, w_launch_dr;
  logic                w_unused_sel;

  assign w_unused_sel = ^i_l2_sel;

  // Head counts as in flight while draining, and also in the IDLE cycle that
  // is about to launch it, so a same-cycle coalesce cannot be lost to pmem.
  assign w_head_busy = (r_state == DRAIN) ||
                       ((r_state == IDLE) && !r_rd_pend && (r_count != '0));

  evict_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .i_valid     (r_valid),
    .i_adr       (r_adr),
    .i_key       (i_l2_adr),
    .i_head      (r_head),
    .i_head_busy (w_head_busy),
    .o_match     (w_match),
    .o_hit       (w_hit),
    .o_idx       (w_idx),
    .o_head_mask (w_head_mask),
    .o_cidx      (w_cidx)
  );

  assign w_chit = |(w_match & ~w_head_mask);
  // A second match can only exist alongside the in-flight head; the
  // non-head copy is the newer data.
  assign w_rd_idx = w_chit ? w_cidx : w_idx;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_req      = i_l2_stb && i_l2_cyc && !r_ack && !r_rd_pend;
  assign w_wr_coal  = w_req && i_l2_we && w_chit;
  assign w_wr_alloc = w_req && i_l2_we && !w_chit && !w_full;
  assign w_rd_hit   = w_req && !i_l2_we && w_hit;
  assign w_rd_miss  = w_req && !i_l2_we && !w_hit;
  assign w_pop      = (r_state == DRAIN) && i_mem_ack;
  assign w_rd_done  = (r_state == READ) && i_mem_ack;

  // FSM next state; a read miss sampled this very cycle launches directly.
  always_comb begin
    w_state_nxt = r_state;
    w_launch_rd = 1'b0;
    w_launch_dr = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rd_pend || w_rd_miss) begin
          w_state_nxt = READ;
          w_launch_rd = 1'b1;
        end else if (r_count != '0) begin
          w_state_nxt = DRAIN;
          w_launch_dr = 1'b1;
        end
      end
      DRAIN:   if (i_mem_ack) w_state_nxt = IDLE;
      READ:    if (i_mem_ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Line storage; contents are meaningless unless the valid bit is set.
  always_ff @(posedge clk) begin
    if (w_wr_coal) r_data[w_cidx] <= i_l2_dat_m;
    if (w_wr_alloc) begin
      r_adr[r_tail]  <= i_l2_adr;
      r_data[r_tail] <= i_l2_dat_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_rd_pend <= 1'b0;
      r_rd_adr  <= '0;
      r_ack     <= 1'b0;
      r_dat_s   <= '0;
      r_mem_adr <= '0;
      r_mem_dat <= '0;
      r_mem_we  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_wr_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_wr_alloc) - CNT_W'(w_pop);

      if (w_rd_miss) begin
        r_rd_pend <= 1'b1;
        r_rd_adr  <= i_l2_adr;
      end else if (w_rd_done) begin
        r_rd_pend <= 1'b0;
      end

      r_ack <= w_wr_coal || w_wr_alloc || w_rd_hit || w_rd_done;
      if (w_rd_hit)       r_dat_s <= r_data[w_rd_idx];
      else if (w_rd_done) r_dat_s <= i_mem_dat_s;

      if (w_launch_dr) begin
        r_mem_adr <= r_adr[r_head];
        r_mem_dat <= r_data[r_head];
        r_mem_we  <= 1'b1;
      end else if (w_launch_rd) begin
        r_mem_adr <= r_rd_pend ? r_rd_adr : i_l2_adr;
        r_mem_we  <= 1'b0;
      end
    end
  end

  assign o_l2_ack    = r_ack;
  assign o_l2_dat_s  = r_dat_s;
  assign o_mem_adr   = r_mem_adr;
  assign o_mem_dat_m = r_mem_dat;
  assign o_mem_stb   = (r_state != IDLE);
  assign o_mem_cyc   = (r_state != IDLE);
  assign o_mem_we    = r_mem_we;
  assign o_mem_sel   = '1;
  assign o_full      = w_full;
  assign o_busy      = (r_count != '0) || (r_state != IDLE);

endmodule

// File: tb/tb_l2_evict_buffer.sv
module tb_l2_evict_buffer;

  logic         clk, rst;
  logic [11:0]  l2_adr;
  logic [127:0] l2_dat_m;
  logic         l2_stb, l2_cyc, l2_we;
  logic [15:0]  l2_sel;
  logic [127:0] l2_dat_s;
  logic         l2_ack;
  logic [11:0]  mem_adr;
  logic [127:0] mem_dat_m;
  logic         mem_stb, mem_cyc, mem_we;
  logic [15:0]  mem_sel;
  logic [127:0] mem_dat_s;
  logic         mem_ack;
  logic         full, busy;

  l2_evict_buffer dut (
    .clk (clk), .rst (rst),
    .i_l2_adr (l2_adr), .i_l2_dat_m (l2_dat_m), .i_l2_stb (l2_stb),
    .i_l2_cyc (l2_cyc), .i_l2_we (l2_we), .i_l2_sel (l2_sel),
    .o_l2_dat_s (l2_dat_s), .o_l2_ack (l2_ack),
    .o_mem_adr (mem_adr), .o_mem_dat_m (mem_dat_m), .o_mem_stb (mem_stb),
    .o_mem_cyc (mem_cyc), .o_mem_we (mem_we), .o_mem_sel (mem_sel),
    .i_mem_dat_s (mem_dat_s), .i_mem_ack (mem_ack),
    .o_full (full), .o_busy (busy)
  );

  typedef struct {
    logic         we;
    logic [11:0]  adr;
    logic [127:0] dat;
  } mexp_t;

  mexp_t        exp_q[$];
  logic [127:0] rd_q[$];
  int tr_start[$], tr_ack[$], tr_we[$];
  int checks = 0, failures = 0;
  int cyc = 0;
  int mem_wr_cnt = 0;
  int pm_delay = 1, pm_cnt = 0;
  logic pm_hold = 1'b0, prev_stb = 1'b0;
  int last_drv_cyc, last_ack_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] mkdat(input int a, input int t);
    return {32'(a), 32'(t), 32'h5A5A0000 ^ 32'(a), ~32'(t)};
  endfunction

  function automatic logic [127:0] rdgen(input logic [11:0] a);
    return {4{20'hC0DE0, a}};
  endfunction

  task automatic push_wr(input logic [11:0] a, input logic [127:0] d);
    mexp_t e;
    e.we = 1'b1; e.adr = a; e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [11:0] a);
    mexp_t e;
    e.we = 1'b0; e.adr = a; e.dat = '0;
    exp_q.push_back(e);
  endtask

  // pmem responder: evaluated shortly after each rising edge.
  initial begin
    mexp_t e;
    mem_ack = 1'b0;
    mem_dat_s = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (rst) begin
        pm_cnt = 0;
        prev_stb = 1'b0;
      end else begin
        if (mem_stb && !prev_stb) tr_start.push_back(cyc);
        prev_stb = mem_stb;
        if (mem_stb && !pm_hold) begin
          pm_cnt++;
          if (pm_cnt >= pm_delay) begin
            pm_cnt = 0;
            mem_ack = 1'b1;
            mem_dat_s = rdgen(mem_adr);
            tr_ack.push_back(cyc);
            tr_we.push_back(int'(mem_we));
            if (mem_we) mem_wr_cnt++;
            if (exp_q.size() == 0) begin
              chk("mem_unexpected", {116'd0, mem_adr}, 128'hFFF);
            end else begin
              e = exp_q.pop_front();
              chk("mem_we", mem_we, e.we);
              chk("mem_adr", mem_adr, e.adr);
              if (e.we) chk("mem_dat", mem_dat_m, e.dat);
            end
          end
        end
      end
    end
  end

  // Called at a falling edge; returns after the ack plus one idle cycle.
  task automatic l2_write(input logic [11:0] a, input logic [127:0] d, output int lat);
    int n = 0;
    last_drv_cyc = cyc;
    l2_adr = a; l2_dat_m = d; l2_we = 1'b1; l2_stb = 1'b1; l2_cyc = 1'b1;
    do begin @(negedge clk); n++; end while (!l2_ack && n < 200);
    chk("wr_ack", l2_ack, 1'b1);
    last_ack_cyc = cyc;
    l2_stb = 1'b0; l2_cyc = 1'b0; l2_we = 1'b0;
    lat = n;
    @(negedge clk);
  endtask

  task automatic l2_read(input logic [11:0] a, input logic [127:0] expd, output int lat);
    int n = 0;
    rd_q.push_back(expd);
    last_drv_cyc = cyc;
    l2_adr = a; l2_we = 1'b0; l2_stb = 1'b1; l2_cyc = 1'b1;
    do begin @(negedge clk); n++; end while (!l2_ack && n < 200);
    chk("rd_ack", l2_ack, 1'b1);
    chk("rd_data", l2_dat_s, rd_q.pop_front());
    last_ack_cyc = cyc;
    l2_stb = 1'b0; l2_cyc = 1'b0;
    lat = n;
    @(negedge clk);
  endtask

  task automatic wait_idle(output int icyc);
    int n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    chk("idle_timeout", busy, 1'b0);
    icyc = cyc;
  endtask

  initial begin
    int lat, lat5, icyc, a, n, base, t0, s0;
    logic [11:0] wa[3];
    rst = 1'b1;
    l2_adr = '0; l2_dat_m = '0; l2_stb = 1'b0; l2_cyc = 1'b0; l2_we = 1'b0;
    l2_sel = '1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_ack", l2_ack, 1'b0);
    chk("rst_dat_s", l2_dat_s, '0);
    chk("rst_stb_cyc_we", {mem_stb, mem_cyc, mem_we}, 3'b000);
    chk("rst_mem_adr", mem_adr, '0);
    chk("rst_mem_dat", mem_dat_m, '0);
    chk("rst_full_busy", {full, busy}, 2'b00);
    chk("rst_mem_sel", mem_sel, 16'hFFFF);
    rst = 1'b0;
    @(negedge clk);

    // three writes, slow pmem, in-order drain
    pm_delay = 5;
    wa[0] = 12'h010; wa[1] = 12'h020; wa[2] = 12'h030;
    base = mem_wr_cnt;
    for (int i = 0; i < 3; i++) push_wr(wa[i], mkdat(wa[i], i));
    for (int i = 0; i < 3; i++) begin
      l2_write(wa[i], mkdat(wa[i], i), lat);
      chk("t1_wr_lat", lat, 1);
    end
    chk("t1_busy", busy, 1'b1);
    wait_idle(icyc);
    chk("t1_wr_cnt", mem_wr_cnt - base, 3);
    chk("t1_busy_fall", icyc, tr_ack[tr_ack.size()-1] + 1);

    // fill while pmem stalled, fifth write stalls
    pm_delay = 1;
    pm_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push_wr(12'h050 + 12'(i), mkdat(12'h050 + i, 10 + i));
    push_wr(12'h050, mkdat(12'h050, 9));
    for (int i = 1; i <= 4; i++) l2_write(12'h050 + 12'(i), mkdat(12'h050 + i, 10 + i), lat);
    chk("t2_full", full, 1'b1);
    a = 0;
    fork
      l2_write(12'h050, mkdat(12'h050, 9), lat5);
      begin
        repeat (6) @(negedge clk);
        chk("t2_stall_noack", l2_ack, 1'b0);
        pm_hold = 1'b0;
        n = 0;
        while (!mem_ack && n < 50) begin @(negedge clk); n++; end
        chk("t2_first_ack", mem_ack, 1'b1);
        a = cyc;
        @(negedge clk);
        chk("t2_full_fall", full, 1'b0);
        @(negedge clk);
        chk("t2_full_rise", full, 1'b1);
      end
    join
    chk("t2_ack_after_free", last_ack_cyc - a, 2);
    chk("t2_stalled", lat5 > 6, 1'b1);
    wait_idle(icyc);

    // coalescing behind an in-flight drain
    pm_hold = 1'b1;
    base = mem_wr_cnt;
    push_wr(12'h0A0, mkdat(12'h0A0, 1));
    push_wr(12'h040, mkdat(12'h040, 2));
    l2_write(12'h0A0, mkdat(12'h0A0, 1), lat);
    l2_write(12'h040, mkdat(12'h040, 3), lat);
    l2_write(12'h040, mkdat(12'h040, 2), lat);
    chk("t3_count", dut.r_count, 3'd2);
    l2_read(12'h040, mkdat(12'h040, 2), lat);
    pm_hold = 1'b0;
    wait_idle(icyc);
    chk("t3_wr_cnt", mem_wr_cnt - base, 2);

    // read hits: buffered entry and in-flight head
    pm_hold = 1'b1;
    t0 = tr_ack.size();
    push_wr(12'h0B0, mkdat(12'h0B0, 4));
    push_wr(12'h060, mkdat(12'h060, 5));
    l2_write(12'h0B0, mkdat(12'h0B0, 4), lat);
    l2_write(12'h060, mkdat(12'h060, 5), lat);
    l2_read(12'h060, mkdat(12'h060, 5), lat);
    chk("t4_hit_lat", lat, 1);
    chk("t4_no_pmem_read", {mem_we, mem_adr}, {1'b1, 12'h0B0});
    l2_read(12'h0B0, mkdat(12'h0B0, 4), lat);
    chk("t4_head_hit_lat", lat, 1);
    pm_hold = 1'b0;
    wait_idle(icyc);
    chk("t4_pmem_txns", tr_ack.size() - t0, 2);

    // read miss during a drain is served before remaining drains
    pm_hold = 1'b1;
    push_wr(12'h070, mkdat(12'h070, 6));
    push_rd(12'h080);
    push_wr(12'h071, mkdat(12'h071, 7));
    push_wr(12'h072, mkdat(12'h072, 8));
    l2_write(12'h070, mkdat(12'h070, 6), lat);
    l2_write(12'h071, mkdat(12'h071, 7), lat);
    l2_write(12'h072, mkdat(12'h072, 8), lat);
    t0 = tr_ack.size();
    fork
      l2_read(12'h080, rdgen(12'h080), lat);
      begin
        repeat (4) @(negedge clk);
        pm_hold = 1'b0;
      end
    join
    wait_idle(icyc);
    chk("t5_read_second", tr_we[t0+1], 0);
    chk("t5_read_start", tr_start[t0+1] - tr_ack[t0], 2);
    chk("t5_l2_ack", last_ack_cyc - tr_ack[t0+1], 1);

    // read miss with pmem idle
    push_rd(12'h090);
    s0 = tr_start.size();
    l2_read(12'h090, rdgen(12'h090), lat);
    chk("t5b_stb_rise", tr_start[s0] - last_drv_cyc, 1);
    chk("t5b_lat", lat, 2);

    // reset during a drain
    pm_hold = 1'b1;
    l2_write(12'h0C0, mkdat(12'h0C0, 11), lat);
    l2_write(12'h0C1, mkdat(12'h0C1, 12), lat);
    chk("t6_stb_before", mem_stb, 1'b1);
    base = mem_wr_cnt;
    #2 rst = 1'b1;
    #1;
    chk("t6_stb_drop", {mem_stb, mem_cyc, mem_we}, 3'b000);
    chk("t6_rst_outs", {l2_ack, full, busy}, 3'b000);
    chk("t6_rst_adr_dat", {mem_adr, mem_dat_m, l2_dat_s}, '0);
    chk("t6_count", dut.r_count, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    pm_hold = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_writes", mem_wr_cnt - base, 0);
    chk("t6_idle", {busy, mem_stb}, 2'b00);

    chk("sb_mem_empty", exp_q.size(), 0);
    chk("sb_rd_empty", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
